// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch FSM encoding, queue entry, NOP.
// Imported by the fetch queue and its FIFO consumers.
package pipeline_pkg;

  localparam int PKG_XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fq_state_t;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pc4;
    logic [31:0]         instr;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: imem request/response, redirect and ID handshake.
// master = fetch queue side, slave = memory/ID side.
interface if_fetch_queue_if #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 10
);

  logic                     imem_req;
  logic [IMEM_AW-1:0]       imem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [31:0]              imem_rdata;
  logic                     redirect;
  logic [XLEN-1:0]          redirect_pc;
  logic                     id_valid;
  logic                     id_ready;
  logic [31:0]              id_instruct;
  logic [XLEN-1:0]          id_pc;
  logic [XLEN-1:0]          id_pc4;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output id_valid, id_instruct, id_pc, id_pc4,
    input  id_ready,
    output fifo_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  id_valid, id_instruct, id_pc, id_pc4,
    output id_ready,
    input  fifo_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Registered-storage synchronous FIFO with flush.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & (r_count != CW'(DEPTH));
  assign w_pop   = i_pop & (r_count != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush)
      r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC, one-outstanding imem port, redirect
// handling and a queue of fetched words toward ID.
module if_fetch_queue
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               i_clk,
  input logic               i_rst,
  if_fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN + 32;
  localparam logic [XLEN-1:0] PC_RST = {RESET_PC[XLEN-1:2], 2'b00};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
  } entry_t;

  fq_state_t       r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;

  logic [CW-1:0]   w_count;
  logic            w_valid;
  logic            w_rsp;
  logic            w_keep;
  logic            w_issue;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  entry_t          w_wdata;
  entry_t          w_head;
  logic            w_unused;

  assign w_valid = (w_count != '0);
  assign w_rsp   = bus.imem_rvalid & (r_state != IDLE);
  assign w_keep  = bus.imem_rvalid & (r_state == WAIT);

  // Credit ignores a same-cycle pop so Req never depends on ID_Ready.
  assign w_issue = ~bus.redirect
                 & ((r_state == IDLE) | w_rsp)
                 & ((w_count + CW'(w_keep)) < CW'(DEPTH));

  assign bus.imem_req  = w_issue & ~i_rst;
  assign bus.imem_addr = r_fetch_pc[IMEM_AW+1:2];
  assign w_grant       = bus.imem_req & bus.imem_gnt;

  assign w_push = w_keep & ~bus.redirect;
  assign w_pop  = w_valid & bus.id_ready & ~bus.redirect;

  assign w_wdata.pc    = r_req_pc;
  assign w_wdata.pc4   = r_req_pc + XLEN'(4);
  assign w_wdata.instr = bus.imem_rdata;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (bus.redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign bus.id_valid    = w_valid;
  assign bus.id_instruct = w_valid ? w_head.instr : NOP;
  assign bus.id_pc       = w_valid ? w_head.pc : '0;
  assign bus.id_pc4      = w_valid ? w_head.pc4 : '0;
  assign bus.fifo_count  = w_count;

  assign w_unused = ^bus.redirect_pc[1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= PC_RST;
      r_req_pc   <= PC_RST;
    end else begin
      if (w_grant)
        r_req_pc <= r_fetch_pc;
      // A response arriving with the redirect is consumed here.
      if (bus.redirect) begin
        r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        r_state    <= (r_state != IDLE && !bus.imem_rvalid)
                    ? DROP : IDLE;
      end else if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_state    <= WAIT;
      end else if (w_rsp) begin
        r_state <= IDLE;
      end
    end
  end

  a_rvalid_in_idle: assert property (
    @(posedge i_clk) disable iff (i_rst)
    !(bus.imem_rvalid && r_state == IDLE)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed vector bench for if_fetch_queue with a
// variable-latency single-outstanding imem model.
module tb_if_fetch_queue;

  localparam logic [31:0] PAT = 32'h1300_0000;

  typedef struct packed {
    logic        rb;
    logic [1:0]  lat;
    logic        rdy;
    logic        red;
    logic [31:0] rpc;
    logic        gnt;
    logic        e_req;
    logic [9:0]  e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       gnt_en;
  logic [1:0] lat;
  logic [1:0] rsp_wait;
  logic [31:0] rdata_r;
  int         n_vec;
  int         n_miss;
  vec_t       tbl[$];

  if_fetch_queue_if #(.XLEN(32), .DEPTH(4), .IMEM_AW(10)) bus ();

  if_fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .IMEM_AW  (10),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_gnt    = gnt_en;
  assign bus.imem_rvalid = (rsp_wait == 2'd1);
  assign bus.imem_rdata  = rdata_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wait <= 2'd0;
      rdata_r  <= 32'h0;
    end else if (bus.imem_req && bus.imem_gnt) begin
      rsp_wait <= lat;
      rdata_r  <= PAT | 32'(bus.imem_addr);
    end else if (rsp_wait != 2'd0) begin
      rsp_wait <= rsp_wait - 2'd1;
    end
  end

  task automatic cmp(input int id, input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    if (got !== exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %0h want %0h",
               id, nm, got, exp);
    end
  endtask

  task automatic check(input int id, input logic e_req,
                       input logic [9:0] e_addr,
                       input logic e_v,
                       input logic [31:0] e_pc,
                       input logic [2:0] e_cnt);
    logic [31:0] pc_x;
    logic [31:0] pc4_x;
    logic [31:0] ins_x;
    pc_x  = e_v ? e_pc : 32'h0;
    pc4_x = e_v ? e_pc + 32'd4 : 32'h0;
    ins_x = e_v ? (PAT | 32'(e_pc[11:2])) : 32'h0;
    n_vec++;
    cmp(id, "imem_req", 32'(bus.imem_req), 32'(e_req));
    cmp(id, "imem_addr", 32'(bus.imem_addr), 32'(e_addr));
    cmp(id, "id_valid", 32'(bus.id_valid), 32'(e_v));
    cmp(id, "id_pc", bus.id_pc, pc_x);
    cmp(id, "id_pc4", bus.id_pc4, pc4_x);
    cmp(id, "id_instr", bus.id_instruct, ins_x);
    cmp(id, "fifo_count", 32'(bus.fifo_count), 32'(e_cnt));
  endtask

  task automatic add(input logic rb, input logic [1:0] l,
                     input logic rdy, input logic red,
                     input logic [31:0] rpc, input logic g,
                     input logic q, input logic [9:0] a,
                     input logic v, input logic [31:0] pc,
                     input logic [2:0] c);
    vec_t x;
    x = '{rb, l, rdy, red, rpc, g, q, a, v, pc, c};
    tbl.push_back(x);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    gnt_en = 1'b0;
    lat    = 2'd1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready    = 1'b0;

    // Streaming: Gnt=1, 1-cycle Rvalid, ID always ready
    add(1, 1, 1, 0, 0, 1,  1, 10'h0, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h1, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h2, 1, 32'h0, 1);
    add(0, 1, 1, 0, 0, 1,  1, 10'h3, 1, 32'h4, 1);
    add(0, 1, 1, 0, 0, 1,  1, 10'h4, 1, 32'h8, 1);
    // Fill to DEPTH with ID stalled, then release
    add(1, 1, 0, 0, 0, 1,  1, 10'h0, 0, 32'h0, 0);
    add(0, 1, 0, 0, 0, 1,  1, 10'h1, 0, 32'h0, 0);
    add(0, 1, 0, 0, 0, 1,  1, 10'h2, 1, 32'h0, 1);
    add(0, 1, 0, 0, 0, 1,  1, 10'h3, 1, 32'h0, 2);
    add(0, 1, 0, 0, 0, 1,  0, 10'h4, 1, 32'h0, 3);
    add(0, 1, 0, 0, 0, 1,  0, 10'h4, 1, 32'h0, 4);
    add(0, 1, 1, 0, 0, 1,  0, 10'h4, 1, 32'h0, 4);
    add(0, 1, 1, 0, 0, 1,  1, 10'h4, 1, 32'h4, 3);
    add(0, 1, 1, 0, 0, 1,  1, 10'h5, 1, 32'h8, 2);
    add(0, 1, 1, 0, 0, 1,  1, 10'h6, 1, 32'hC, 2);
    add(0, 1, 1, 0, 0, 1,  1, 10'h7, 1, 32'h10, 2);
    // Redirect while WAIT without Rvalid -> DROP
    add(1, 2, 0, 0, 0, 1,  1, 10'h0, 0, 32'h0, 0);
    add(0, 2, 0, 0, 0, 1,  0, 10'h1, 0, 32'h0, 0);
    add(0, 2, 0, 0, 0, 1,  1, 10'h1, 0, 32'h0, 0);
    add(0, 2, 0, 1, 32'h103, 1,  0, 10'h2, 1, 32'h0, 1);
    add(0, 2, 0, 0, 0, 1,  1, 10'h40, 0, 32'h0, 0);
    add(0, 2, 0, 0, 0, 1,  0, 10'h41, 0, 32'h0, 0);
    add(0, 2, 0, 0, 0, 1,  1, 10'h41, 0, 32'h0, 0);
    add(0, 2, 0, 0, 0, 1,  0, 10'h42, 1, 32'h100, 1);
    // Redirect with Rvalid and a pop in the same cycle
    add(1, 1, 1, 0, 0, 1,  1, 10'h0, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h1, 0, 32'h0, 0);
    add(0, 1, 1, 1, 32'h200, 1,  0, 10'h2, 1, 32'h0, 1);
    add(0, 1, 1, 0, 0, 1,  1, 10'h80, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h81, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h82, 1, 32'h200, 1);
    // Grant withheld for three cycles
    add(1, 1, 1, 0, 0, 0,  1, 10'h0, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 0,  1, 10'h0, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 0,  1, 10'h0, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h0, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h1, 0, 32'h0, 0);
    add(0, 1, 1, 0, 0, 1,  1, 10'h2, 1, 32'h0, 1);

    foreach (tbl[i]) begin
      lat = tbl[i].lat;
      if (tbl[i].rb) pulse_reset();
      else @(negedge clk);
      bus.id_ready    = tbl[i].rdy;
      bus.redirect    = tbl[i].red;
      bus.redirect_pc = tbl[i].rpc;
      gnt_en          = tbl[i].gnt;
      #1;
      check(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v,
            tbl[i].e_pc, tbl[i].e_cnt);
    end

    // Asynchronous reset in WAIT with a non-empty queue
    lat = 2'd1;
    pulse_reset();
    bus.id_ready = 1'b0;
    bus.redirect = 1'b0;
    gnt_en       = 1'b1;
    #1 check(100, 1, 10'h0, 0, 32'h0, 0);
    @(negedge clk);
    #1 check(101, 1, 10'h1, 0, 32'h0, 0);
    @(negedge clk);
    #1 check(102, 1, 10'h2, 1, 32'h0, 1);
    #2 rst = 1'b1;
    #1 check(103, 0, 10'h0, 0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check(104, 1, 10'h0, 0, 32'h0, 0);
    @(negedge clk);
    #1 check(105, 1, 10'h1, 0, 32'h0, 0);
    @(negedge clk);
    #1 check(106, 1, 10'h2, 1, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
